// File: rtl/decode_control_unit.sv
// ID-stage decode/control for the ARM-subset pipeline: combinational decode, one-cycle flag register for branch conditions.
// Build with DECODE_KEYWORD_EN defined to drive the ASCII mnemonic on keyword; otherwise keyword is tied to zero.
module decode_control_unit (
    input  logic        clk,
    input  logic        R,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic [3:0]  alu_flags,
    input  logic [3:0]  psr_flags,
    input  logic        ex_s_enable,
    output logic [3:0]  id_opcode,
    output logic [1:0]  id_am,
    output logic        id_s_enable,
    output logic        id_load_instr,
    output logic        id_rf_enable,
    output logic        id_size_enable,
    output logic        id_rw_enable,
    output logic        id_enable_signal,
    output logic        id_bl_instr,
    output logic        id_b_instr,
    output logic        branch,
    output logic        branch_l,
    output logic [3:0]  rd_or_14,
    output logic [47:0] keyword
);

    logic [3:0] flag_q;
    logic [3:0] flag_d;

    logic [3:0] dec_opcode;
    logic [1:0] dec_am;
    logic       dec_s;
    logic       dec_load;
    logic       dec_rf;
    logic       dec_size;
    logic       dec_rw;
    logic       dec_en;
    logic       dec_b;
    logic       dec_bl;

    logic [3:0] sel_flags;
    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;
    logic       cond_pass;
    logic       rf_final;

    assign flag_d = alu_flags;

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            flag_q <= 4'b0000;
        end else begin
            flag_q <= flag_d;
        end
    end

    always_comb begin
        dec_opcode = 4'b0000;
        dec_am     = 2'b00;
        dec_s      = 1'b0;
        dec_load   = 1'b0;
        dec_rf     = 1'b0;
        dec_size   = 1'b0;
        dec_rw     = 1'b0;
        dec_en     = 1'b0;
        dec_b      = 1'b0;
        dec_bl     = 1'b0;
        if (instruction != 32'h0) begin
            case (instruction[27:25])
                3'b000, 3'b001: begin
                    dec_opcode = instruction[24:21];
                    dec_am     = instruction[25] ? 2'b00 : 2'b01;
                    dec_s      = instruction[20];
                    // TST/TEQ/CMP/CMN only set flags
                    dec_rf     = (instruction[24:23] != 2'b10);
                end
                3'b010, 3'b011: begin
                    dec_opcode = instruction[23] ? 4'b0100 : 4'b0010;
                    dec_am     = {1'b1, instruction[25]};
                    dec_size   = instruction[22];
                    dec_load   = instruction[20];
                    dec_rf     = instruction[20];
                    dec_rw     = ~instruction[20];
                    dec_en     = 1'b1;
                end
                3'b101: begin
                    dec_b  = ~instruction[24];
                    dec_bl = instruction[24];
                end
                default: begin
                end
            endcase
        end
    end

    // Forwarded flags are only valid when the EX instruction actually updates them
    assign sel_flags = ex_s_enable ? flag_q : psr_flags;
    assign flag_n    = sel_flags[3];
    assign flag_z    = sel_flags[2];
    assign flag_c    = sel_flags[1];
    assign flag_v    = sel_flags[0];

    always_comb begin
        cond_pass = 1'b0;
        case (instruction[31:28])
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = ~flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = ~flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = ~flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = ~flag_v;
            4'b1000: cond_pass = flag_c & ~flag_z;
            4'b1001: cond_pass = ~flag_c | flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_pass = flag_z | (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    assign branch   = (dec_b | dec_bl) & cond_pass;
    assign branch_l = dec_bl & cond_pass;
    assign rd_or_14 = branch_l ? 4'd14 : instruction[15:12];
    assign rf_final = branch_l | dec_rf;

    assign id_opcode        = stall ? 4'b0000 : dec_opcode;
    assign id_am            = stall ? 2'b00   : dec_am;
    assign id_s_enable      = ~stall & dec_s;
    assign id_load_instr    = ~stall & dec_load;
    assign id_rf_enable     = ~stall & rf_final;
    assign id_size_enable   = ~stall & dec_size;
    assign id_rw_enable     = ~stall & dec_rw;
    assign id_enable_signal = ~stall & dec_en;
    assign id_bl_instr      = ~stall & dec_bl;
    assign id_b_instr       = ~stall & dec_b;

`ifdef DECODE_KEYWORD_EN
    always_comb begin
        keyword = {24'h0, "NOP"};
        if (instruction != 32'h0) begin
            case (instruction[27:25])
                3'b000, 3'b001: begin
                    case (instruction[24:21])
                        4'b0000: keyword = {24'h0, "AND"};
                        4'b0001: keyword = {24'h0, "EOR"};
                        4'b0010: keyword = {24'h0, "SUB"};
                        4'b0011: keyword = {24'h0, "RSB"};
                        4'b0100: keyword = {24'h0, "ADD"};
                        4'b0101: keyword = {24'h0, "ADC"};
                        4'b0110: keyword = {24'h0, "SBC"};
                        4'b0111: keyword = {24'h0, "RSC"};
                        4'b1000: keyword = {24'h0, "TST"};
                        4'b1001: keyword = {24'h0, "TEQ"};
                        4'b1010: keyword = {24'h0, "CMP"};
                        4'b1011: keyword = {24'h0, "CMN"};
                        4'b1100: keyword = {24'h0, "ORR"};
                        4'b1101: keyword = {24'h0, "MOV"};
                        4'b1110: keyword = {24'h0, "BIC"};
                        default: keyword = {24'h0, "MVN"};
                    endcase
                end
                3'b010, 3'b011: begin
                    case ({instruction[20], instruction[22]})
                        2'b10:   keyword = {24'h0, "LDR"};
                        2'b11:   keyword = {16'h0, "LDRB"};
                        2'b00:   keyword = {24'h0, "STR"};
                        default: keyword = {16'h0, "STRB"};
                    endcase
                end
                3'b101: keyword = instruction[24] ? {32'h0, "BL"} : {40'h0, "B"};
                default: keyword = {24'h0, "NOP"};
            endcase
        end
    end
`else
    assign keyword = 48'h0;
`endif

endmodule

// File: tb/tb_decode_control_unit.sv
// Scoreboard bench for decode_control_unit: expected output vectors are queued per stimulus and popped on sampling.
module tb_decode_control_unit;

    logic        clk = 1'b0;
    logic        R;
    logic [31:0] instruction;
    logic        stall;
    logic [3:0]  alu_flags;
    logic [3:0]  psr_flags;
    logic        ex_s_enable;
    logic [3:0]  id_opcode;
    logic [1:0]  id_am;
    logic        id_s_enable;
    logic        id_load_instr;
    logic        id_rf_enable;
    logic        id_size_enable;
    logic        id_rw_enable;
    logic        id_enable_signal;
    logic        id_bl_instr;
    logic        id_b_instr;
    logic        branch;
    logic        branch_l;
    logic [3:0]  rd_or_14;
    logic [47:0] keyword;

    decode_control_unit dut (
        .clk(clk), .R(R), .instruction(instruction), .stall(stall),
        .alu_flags(alu_flags), .psr_flags(psr_flags), .ex_s_enable(ex_s_enable),
        .id_opcode(id_opcode), .id_am(id_am), .id_s_enable(id_s_enable),
        .id_load_instr(id_load_instr), .id_rf_enable(id_rf_enable),
        .id_size_enable(id_size_enable), .id_rw_enable(id_rw_enable),
        .id_enable_signal(id_enable_signal), .id_bl_instr(id_bl_instr),
        .id_b_instr(id_b_instr), .branch(branch), .branch_l(branch_l),
        .rd_or_14(rd_or_14), .keyword(keyword)
    );

    always #5 clk = ~clk;

    // bits = {s, load, rf, size, rw, en, bl, b, branch, branch_l}
    typedef struct packed {
        logic [3:0]  opcode;
        logic [1:0]  am;
        logic [9:0]  bits;
        logic [3:0]  rd;
        logic [47:0] kw;
    } out_t;

`ifdef DECODE_KEYWORD_EN
    localparam bit KW_ON = 1'b1;
`else
    localparam bit KW_ON = 1'b0;
`endif

    out_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [31:0] I_ADD  = 32'hE2821005;
    localparam logic [31:0] I_LDR  = 32'hE5921004;
    localparam logic [31:0] I_STRB = 32'hE5423001;
    localparam logic [31:0] I_BEQ  = 32'h0A000003;
    localparam logic [31:0] I_BL   = 32'hEB000010;
    localparam logic [31:0] I_CMP  = 32'hE3510000;

    function automatic out_t ev(input logic [3:0] op, input logic [1:0] am,
                                input logic [9:0] bits, input logic [3:0] rd,
                                input logic [47:0] kw);
        out_t r;
        r = {op, am, bits, rd, kw & {48{KW_ON}}};
        return r;
    endfunction

    function automatic out_t observe();
        out_t r;
        r = {id_opcode, id_am, id_s_enable, id_load_instr, id_rf_enable,
             id_size_enable, id_rw_enable, id_enable_signal, id_bl_instr,
             id_b_instr, branch, branch_l, rd_or_14, keyword};
        return r;
    endfunction

    task automatic apply(input logic [31:0] ins, input logic stl,
                         input logic [3:0] psr, input logic exs, input out_t e);
        @(negedge clk);
        instruction = ins;
        stall       = stl;
        psr_flags   = psr;
        ex_s_enable = exs;
        sb.push_back(e);
        #1;
    endtask

    task automatic test_reset();
        out_t o, e;
        R = 1'b1;
        apply(32'h0, 1'b0, 4'b0000, 1'b1, ev(4'h0, 2'b00, 10'b0000000000, 4'h0, {24'h0, "NOP"}));
        o = observe(); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL reset_nop: got %h expected %h", o, e); end
        R = 1'b0;
    endtask

    task automatic test_data_processing();
        out_t o, e;
        logic [31:0] ins[3];
        out_t        ex[3];
        ins[0] = I_ADD; ex[0] = ev(4'b0100, 2'b00, 10'b0010000000, 4'd1, {24'h0, "ADD"});
        ins[1] = I_CMP; ex[1] = ev(4'b1010, 2'b00, 10'b1000000000, 4'd0, {24'h0, "CMP"});
        ins[2] = 32'hE0000000; ex[2] = ev(4'b0000, 2'b01, 10'b0010000000, 4'd0, {24'h0, "AND"});
        for (int i = 0; i < 3; i++) begin
            apply(ins[i], 1'b0, 4'b0000, 1'b0, ex[i]);
            o = observe(); e = sb.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL dp[%0d]: got %h expected %h", i, o, e); end
        end
    endtask

    task automatic test_load_store();
        out_t o, e;
        apply(I_LDR, 1'b0, 4'b0000, 1'b0, ev(4'b0100, 2'b10, 10'b0110010000, 4'd1, {24'h0, "LDR"}));
        o = observe(); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL ldr: got %h expected %h", o, e); end
        apply(I_STRB, 1'b0, 4'b0000, 1'b0, ev(4'b0010, 2'b10, 10'b0001110000, 4'd3, {16'h0, "STRB"}));
        o = observe(); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL strb: got %h expected %h", o, e); end
    endtask

    task automatic test_branch();
        out_t o, e;
        apply(I_BEQ, 1'b0, 4'b0100, 1'b0, ev(4'h0, 2'b00, 10'b0000000110, 4'd0, {40'h0, "B"}));
        o = observe(); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL beq_taken: got %h expected %h", o, e); end
        apply(I_BEQ, 1'b0, 4'b0000, 1'b0, ev(4'h0, 2'b00, 10'b0000000100, 4'd0, {40'h0, "B"}));
        o = observe(); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL beq_not_taken: got %h expected %h", o, e); end
        apply(I_BL, 1'b0, 4'b0000, 1'b0, ev(4'h0, 2'b00, 10'b0010001011, 4'd14, {32'h0, "BL"}));
        o = observe(); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL bl: got %h expected %h", o, e); end
    endtask

    task automatic test_conditions();
        out_t o, e;
        logic [3:0] cnd[18];
        logic [3:0] flg[18];
        logic       tak[18];
        cnd = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
                4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hC, 4'hD, 4'hE, 4'hF};
        flg = '{4'b0100, 4'b0100, 4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0001, 4'b0000, 4'b0010,
                4'b0110, 4'b0110, 4'b1001, 4'b1000, 4'b0100, 4'b1001, 4'b0000, 4'b0000, 4'b1111};
        tak = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 18; i++) begin
            apply({cnd[i], 28'hA000000}, 1'b0, flg[i], 1'b0,
                  ev(4'h0, 2'b00, {8'b00000001, tak[i], 1'b0}, 4'd0, {40'h0, "B"}));
            o = observe(); e = sb.pop_front(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL cond[%0d] c=%h f=%b: got %h expected %h", i, cnd[i], flg[i], o, e);
            end
        end
    endtask

    task automatic test_flag_path();
        out_t o, e;
        @(negedge clk);
        R = 1'b1;
        alu_flags = 4'b0100;
        instruction = I_BEQ; stall = 1'b0; psr_flags = 4'b0100; ex_s_enable = 1'b1;
        #1 R = 1'b0;
        sb.push_back(ev(4'h0, 2'b00, 10'b0000000100, 4'd0, {40'h0, "B"}));
        #1;
        o = observe(); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL flag_before_edge: got %h expected %h", o, e); end
        @(posedge clk);
        sb.push_back(ev(4'h0, 2'b00, 10'b0000000110, 4'd0, {40'h0, "B"}));
        #1;
        o = observe(); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL flag_after_edge: got %h expected %h", o, e); end
        R = 1'b1;
        sb.push_back(ev(4'h0, 2'b00, 10'b0000000100, 4'd0, {40'h0, "B"}));
        #1;
        o = observe(); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL flag_async_reset: got %h expected %h", o, e); end
        alu_flags = 4'b0000;
        R = 1'b0;
        ex_s_enable = 1'b0;
    endtask

    task automatic test_stall();
        out_t o, e;
        logic [31:0] ins[4];
        out_t        ex[4];
        ins[0] = I_ADD; ex[0] = ev(4'h0, 2'b00, 10'b0000000000, 4'd1,  {24'h0, "ADD"});
        ins[1] = I_LDR; ex[1] = ev(4'h0, 2'b00, 10'b0000000000, 4'd1,  {24'h0, "LDR"});
        ins[2] = I_BL;  ex[2] = ev(4'h0, 2'b00, 10'b0000000011, 4'd14, {32'h0, "BL"});
        ins[3] = I_BEQ; ex[3] = ev(4'h0, 2'b00, 10'b0000000010, 4'd0,  {40'h0, "B"});
        for (int i = 0; i < 4; i++) begin
            apply(ins[i], 1'b1, 4'b0100, 1'b0, ex[i]);
            o = observe(); e = sb.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL stall[%0d]: got %h expected %h", i, o, e); end
        end
    endtask

    task automatic test_other_encodings();
        out_t o, e;
        apply(32'hEE000000, 1'b0, 4'b1111, 1'b0, ev(4'h0, 2'b00, 10'b0000000000, 4'd0, {24'h0, "NOP"}));
        o = observe(); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL undefined_enc: got %h expected %h", o, e); end
        apply(32'h0, 1'b0, 4'b1111, 1'b0, ev(4'h0, 2'b00, 10'b0000000000, 4'd0, {24'h0, "NOP"}));
        o = observe(); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL zero_nop: got %h expected %h", o, e); end
    endtask

    initial begin
        R = 1'b1;
        instruction = 32'h0;
        stall = 1'b0;
        alu_flags = 4'b0000;
        psr_flags = 4'b0000;
        ex_s_enable = 1'b0;
        test_reset();
        test_data_processing();
        test_load_store();
        test_branch();
        test_conditions();
        test_flag_path();
        test_stall();
        test_other_encodings();
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
